// File: rtl/sap1_pkg.sv
// Shared constants for the SAP-1 controller: opcodes, one-hot T-states, control-word bit map.
// Optional build macro SAP1_VARIABLE_CYCLE_EN is consumed by sap1_controller.
package sap1_pkg;

  localparam int unsigned OPCODE_W = 4;
  localparam int unsigned RING_W   = 6;
  localparam int unsigned CW_W     = 12;

  localparam logic [OPCODE_W-1:0] OP_LDA = 4'h0;
  localparam logic [OPCODE_W-1:0] OP_ADD = 4'h1;
  localparam logic [OPCODE_W-1:0] OP_SUB = 4'h2;
  localparam logic [OPCODE_W-1:0] OP_OUT = 4'hE;
  localparam logic [OPCODE_W-1:0] OP_HLT = 4'hF;

  localparam logic [RING_W-1:0] T1 = 6'b000001;
  localparam logic [RING_W-1:0] T2 = 6'b000010;
  localparam logic [RING_W-1:0] T3 = 6'b000100;
  localparam logic [RING_W-1:0] T4 = 6'b001000;
  localparam logic [RING_W-1:0] T5 = 6'b010000;
  localparam logic [RING_W-1:0] T6 = 6'b100000;

  // Bit positions inside the control word
  localparam int unsigned CW_PC_INC   = 0;
  localparam int unsigned CW_PC_SEND  = 1;
  localparam int unsigned CW_MAR_LOAD = 2;
  localparam int unsigned CW_RAM_SEND = 3;
  localparam int unsigned CW_IR_LOAD  = 4;
  localparam int unsigned CW_IR_SEND  = 5;
  localparam int unsigned CW_ACC_LOAD = 6;
  localparam int unsigned CW_ACC_SEND = 7;
  localparam int unsigned CW_ALU_SUB  = 8;
  localparam int unsigned CW_ALU_SEND = 9;
  localparam int unsigned CW_B_LOAD   = 10;
  localparam int unsigned CW_OUT_LOAD = 11;

  typedef logic [CW_W-1:0] ctrl_word_t;

  function automatic logic is_mem_op(input logic [OPCODE_W-1:0] op);
    return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

  function automatic logic is_nop(input logic [OPCODE_W-1:0] op);
    return !(is_mem_op(op) || (op == OP_OUT) || (op == OP_HLT));
  endfunction

endpackage

// File: rtl/sap1_ring_counter.sv
// One-hot T-state ring with synchronous reset, halt freeze and early wrap to T1.
module sap1_ring_counter #(
  parameter int unsigned N = 6
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_halt_req,
  input  logic         i_wrap,
  output logic [N-1:0] o_ring,
  output logic         o_halted
);

  logic [N-1:0] ring_q, ring_d;
  logic         halted_q, halted_d;

  // Next state: halt takes precedence over advance; once halted, everything holds
  always_comb begin
    ring_d   = ring_q;
    halted_d = halted_q;
    if (!halted_q) begin
      if (i_halt_req) begin
        halted_d = 1'b1;
      end else if (i_wrap) begin
        ring_d = N'(1);
      end else begin
        ring_d = {ring_q[N-2:0], ring_q[N-1]};
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ring_q   <= N'(1);
      halted_q <= 1'b0;
    end else begin
      ring_q   <= ring_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    o_ring   = ring_q;
    o_halted = halted_q;
  end

endmodule

// File: rtl/sap1_controller.sv
// SAP-1 controller-sequencer: decodes ring state and opcode into the datapath control word.
// Build option SAP1_VARIABLE_CYCLE_EN returns to T1 right after the last active execute state.
module sap1_controller
  import sap1_pkg::*;
#(
  parameter int unsigned OPCODE_WIDTH = 4,
  parameter int unsigned T_STATES     = 6
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_debug,
  input  logic [OPCODE_WIDTH-1:0] i_opcode,
  output logic [T_STATES-1:0]     o_t_state,
  output logic                    o_halted,
  output logic                    o_pc_increment,
  output logic                    o_pc_send,
  output logic                    o_mar_load,
  output logic                    o_ram_send,
  output logic                    o_ir_load,
  output logic                    o_ir_send,
  output logic                    o_acc_load,
  output logic                    o_acc_send,
  output logic                    o_alu_subtract,
  output logic                    o_alu_send,
  output logic                    o_b_load,
  output logic                    o_out_load
);

`ifdef SAP1_VARIABLE_CYCLE_EN
  localparam bit VARIABLE_CYCLE = 1'b1;
`else
  localparam bit VARIABLE_CYCLE = 1'b0;
`endif

  localparam logic [T_STATES-1:0] S1 = T_STATES'(T1);
  localparam logic [T_STATES-1:0] S2 = T_STATES'(T2);
  localparam logic [T_STATES-1:0] S3 = T_STATES'(T3);
  localparam logic [T_STATES-1:0] S4 = T_STATES'(T4);
  localparam logic [T_STATES-1:0] S5 = T_STATES'(T5);
  localparam logic [T_STATES-1:0] S6 = T_STATES'(T6);

  logic [T_STATES-1:0] ring;
  logic                halted;
  logic                halt_req_c;
  logic                wrap_c;
  ctrl_word_t          cw;
  logic [OPCODE_W-1:0] op;
  logic                unused_debug;

  // i_debug is a trace hook only and never affects sequencing or decode
  always_comb unused_debug = i_debug;

  always_comb op = OPCODE_W'(i_opcode);

  sap1_ring_counter #(
    .N (T_STATES)
  ) u_ring (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_halt_req (halt_req_c),
    .i_wrap     (wrap_c),
    .o_ring     (ring),
    .o_halted   (halted)
  );

  // Decode: fetch is opcode-independent, execute depends on opcode; reset and halt blank the word
  always_comb begin
    cw         = '0;
    halt_req_c = 1'b0;
    wrap_c     = 1'b0;
    if (!halted) begin
      case (ring)
        S1: begin
          cw[CW_PC_SEND]  = 1'b1;
          cw[CW_MAR_LOAD] = 1'b1;
        end
        S2: cw[CW_PC_INC] = 1'b1;
        S3: begin
          cw[CW_RAM_SEND] = 1'b1;
          cw[CW_IR_LOAD]  = 1'b1;
        end
        S4: begin
          if (is_mem_op(op)) begin
            cw[CW_IR_SEND]  = 1'b1;
            cw[CW_MAR_LOAD] = 1'b1;
          end else if (op == OP_OUT) begin
            cw[CW_ACC_SEND] = 1'b1;
            cw[CW_OUT_LOAD] = 1'b1;
          end
          halt_req_c = (op == OP_HLT);
          wrap_c     = VARIABLE_CYCLE && ((op == OP_OUT) || is_nop(op));
        end
        S5: begin
          if (op == OP_LDA) begin
            cw[CW_RAM_SEND] = 1'b1;
            cw[CW_ACC_LOAD] = 1'b1;
          end else if ((op == OP_ADD) || (op == OP_SUB)) begin
            cw[CW_RAM_SEND] = 1'b1;
            cw[CW_B_LOAD]   = 1'b1;
          end
          wrap_c = VARIABLE_CYCLE && (op == OP_LDA);
        end
        S6: begin
          if ((op == OP_ADD) || (op == OP_SUB)) begin
            cw[CW_ALU_SEND] = 1'b1;
            cw[CW_ACC_LOAD] = 1'b1;
            cw[CW_ALU_SUB]  = (op == OP_SUB);
          end
        end
        default: cw = '0;
      endcase
    end
    if (i_reset) begin
      cw = '0;
    end
  end

  always_comb begin
    o_t_state      = ring;
    o_halted       = halted;
    o_pc_increment = cw[CW_PC_INC];
    o_pc_send      = cw[CW_PC_SEND];
    o_mar_load     = cw[CW_MAR_LOAD];
    o_ram_send     = cw[CW_RAM_SEND];
    o_ir_load      = cw[CW_IR_LOAD];
    o_ir_send      = cw[CW_IR_SEND];
    o_acc_load     = cw[CW_ACC_LOAD];
    o_acc_send     = cw[CW_ACC_SEND];
    o_alu_subtract = cw[CW_ALU_SUB];
    o_alu_send     = cw[CW_ALU_SEND];
    o_b_load       = cw[CW_B_LOAD];
    o_out_load     = cw[CW_OUT_LOAD];
  end

endmodule

// File: tb/tb_sap1_controller.sv
// Scoreboard bench for sap1_controller: stimulus pushes hand-derived expectations, a negedge monitor checks them.
module tb_sap1_controller;

  localparam logic [11:0] B_CP = 12'h800;
  localparam logic [11:0] B_EP = 12'h400;
  localparam logic [11:0] B_LM = 12'h200;
  localparam logic [11:0] B_CE = 12'h100;
  localparam logic [11:0] B_LI = 12'h080;
  localparam logic [11:0] B_EI = 12'h040;
  localparam logic [11:0] B_LA = 12'h020;
  localparam logic [11:0] B_EA = 12'h010;
  localparam logic [11:0] B_SU = 12'h008;
  localparam logic [11:0] B_EU = 12'h004;
  localparam logic [11:0] B_LB = 12'h002;
  localparam logic [11:0] B_LO = 12'h001;
  localparam logic [11:0] NONE = 12'h000;

  localparam logic [5:0] S1 = 6'b000001;
  localparam logic [5:0] S2 = 6'b000010;
  localparam logic [5:0] S3 = 6'b000100;
  localparam logic [5:0] S4 = 6'b001000;
  localparam logic [5:0] S5 = 6'b010000;
  localparam logic [5:0] S6 = 6'b100000;

  logic       clk = 1'b0;
  logic       i_reset;
  logic       i_debug;
  logic [3:0] i_opcode;
  logic [5:0] o_t_state;
  logic       o_halted, o_pc_increment, o_pc_send, o_mar_load, o_ram_send, o_ir_load;
  logic       o_ir_send, o_acc_load, o_acc_send, o_alu_subtract, o_alu_send, o_b_load, o_out_load;
  logic [11:0] act_cw;

  typedef struct {
    logic [5:0]  t;
    logic [11:0] cw;
    logic        h;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc_n   = 0;

  always #5 clk = ~clk;

  sap1_controller dut (
    .i_clk          (clk),
    .i_reset        (i_reset),
    .i_debug        (i_debug),
    .i_opcode       (i_opcode),
    .o_t_state      (o_t_state),
    .o_halted       (o_halted),
    .o_pc_increment (o_pc_increment),
    .o_pc_send      (o_pc_send),
    .o_mar_load     (o_mar_load),
    .o_ram_send     (o_ram_send),
    .o_ir_load      (o_ir_load),
    .o_ir_send      (o_ir_send),
    .o_acc_load     (o_acc_load),
    .o_acc_send     (o_acc_send),
    .o_alu_subtract (o_alu_subtract),
    .o_alu_send     (o_alu_send),
    .o_b_load       (o_b_load),
    .o_out_load     (o_out_load)
  );

  assign act_cw = {o_pc_increment, o_pc_send, o_mar_load, o_ram_send, o_ir_load, o_ir_send,
                   o_acc_load, o_acc_send, o_alu_subtract, o_alu_send, o_b_load, o_out_load};

  // One cycle of stimulus plus the outputs expected during that same cycle
  task automatic cyc(input logic rst, input logic [3:0] op, input logic [5:0] t,
                     input logic [11:0] cw, input logic h, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    i_reset  = rst;
    i_opcode = op;
    e.t = t; e.cw = cw; e.h = h; e.name = name;
    sb_q.push_back(e);
  endtask

  // Full instruction from T1 with the opcode held throughout
  task automatic instr(input logic [3:0] op, input string name);
    cyc(1'b0, op, S1, B_EP | B_LM, 1'b0, {name, " T1"});
    cyc(1'b0, op, S2, B_CP,        1'b0, {name, " T2"});
    cyc(1'b0, op, S3, B_CE | B_LI, 1'b0, {name, " T3"});
    case (op)
      4'h0: begin
        cyc(1'b0, op, S4, B_EI | B_LM, 1'b0, {name, " T4"});
        cyc(1'b0, op, S5, B_CE | B_LA, 1'b0, {name, " T5"});
`ifndef SAP1_VARIABLE_CYCLE_EN
        cyc(1'b0, op, S6, NONE, 1'b0, {name, " T6"});
`endif
      end
      4'h1: begin
        cyc(1'b0, op, S4, B_EI | B_LM, 1'b0, {name, " T4"});
        cyc(1'b0, op, S5, B_CE | B_LB, 1'b0, {name, " T5"});
        cyc(1'b0, op, S6, B_EU | B_LA, 1'b0, {name, " T6"});
      end
      4'h2: begin
        cyc(1'b0, op, S4, B_EI | B_LM, 1'b0, {name, " T4"});
        cyc(1'b0, op, S5, B_CE | B_LB, 1'b0, {name, " T5"});
        cyc(1'b0, op, S6, B_EU | B_LA | B_SU, 1'b0, {name, " T6"});
      end
      4'hE: begin
        cyc(1'b0, op, S4, B_EA | B_LO, 1'b0, {name, " T4"});
`ifndef SAP1_VARIABLE_CYCLE_EN
        cyc(1'b0, op, S5, NONE, 1'b0, {name, " T5"});
        cyc(1'b0, op, S6, NONE, 1'b0, {name, " T6"});
`endif
      end
      4'hF: cyc(1'b0, op, S4, NONE, 1'b0, {name, " T4"});
      default: begin
        cyc(1'b0, op, S4, NONE, 1'b0, {name, " T4"});
`ifndef SAP1_VARIABLE_CYCLE_EN
        cyc(1'b0, op, S5, NONE, 1'b0, {name, " T5"});
        cyc(1'b0, op, S6, NONE, 1'b0, {name, " T6"});
`endif
      end
    endcase
  endtask

  // Monitor: outputs are valid every cycle, so one expectation is consumed per negedge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc_n++;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_tests++;
        if (o_t_state !== e.t || act_cw !== e.cw || o_halted !== e.h) begin
          n_fail++;
          $display("FAIL %s (cycle %0d): got t_state=%b cw=%h halted=%b, expected t_state=%b cw=%h halted=%b",
                   e.name, cyc_n, o_t_state, act_cw, o_halted, e.t, e.cw, e.h);
        end
        n_tests++;
        if ($countones({o_pc_send, o_ram_send, o_ir_send, o_acc_send, o_alu_send}) > 1) begin
          n_fail++;
          $display("FAIL bus_senders %s (cycle %0d): got senders=%b, expected at most one high",
                   e.name, cyc_n, {o_pc_send, o_ram_send, o_ir_send, o_acc_send, o_alu_send});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of stimulus by time %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] ops [6];
    ops[0] = 4'h0; ops[1] = 4'h1; ops[2] = 4'h2;
    ops[3] = 4'hE; ops[4] = 4'h5; ops[5] = 4'h9;
    i_reset  = 1'b1;
    i_opcode = 4'h0;
    i_debug  = 1'b0;

    cyc(1'b1, 4'h1, S1, NONE, 1'b0, "reset cycle 0");
    cyc(1'b1, 4'h1, S1, NONE, 1'b0, "reset cycle 1");

    instr(4'h1, "ADD");
    instr(4'h2, "SUB");
    instr(4'h0, "LDA");
    instr(4'hE, "OUT");
    instr(4'h5, "NOP5");
    i_debug = 1'b1;
    instr(4'h2, "SUB debug");
    i_debug = 1'b0;

    // Reset arriving in T5 of an ADD: word blanked immediately, T1 on the next edge
    cyc(1'b0, 4'h1, S1, B_EP | B_LM, 1'b0, "ADDrst T1");
    cyc(1'b0, 4'h1, S2, B_CP,        1'b0, "ADDrst T2");
    cyc(1'b0, 4'h1, S3, B_CE | B_LI, 1'b0, "ADDrst T3");
    cyc(1'b0, 4'h1, S4, B_EI | B_LM, 1'b0, "ADDrst T4");
    cyc(1'b1, 4'h1, S5, NONE,        1'b0, "ADDrst T5 in reset");
    instr(4'h1, "ADD after reset");

    for (int k = 0; k < 170; k++) begin
      instr(ops[$urandom_range(0, 5)], "RND");
    end

    instr(4'hF, "HLT");
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0, (k % 2 == 0) ? 4'h1 : 4'hF, S4, NONE, 1'b1, "HLT frozen");
    end
    cyc(1'b1, 4'hF, S4, NONE, 1'b1, "HLT reset cycle");
    instr(4'h0, "LDA after halt");

    repeat (3) @(posedge clk);
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
